// File: rtl/addsub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addsub_pkg : FSM state encoding and step-count helper for addsub_serial_n  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of digit cycles needed to cover the full operand width.
   function automatic int calc_steps(input int width, input int digit);
      return width / digit;
   endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_digit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addsub_digit : combinational DIGIT-bit ripple-carry adder slice            |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module addsub_digit #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             c_in,
   output logic [DIGIT-1:0] s_d,
   output logic             c_out
);

   logic [DIGIT:0] carry_w;

   assign carry_w[0] = c_in;

   for (genvar k = 0; k < DIGIT; k++) begin : g_bit
      assign s_d[k]       = a_d[k] ^ b_d[k] ^ carry_w[k];
      assign carry_w[k+1] = (a_d[k] & b_d[k]) | (carry_w[k] & (a_d[k] ^ b_d[k]));
   end

   assign c_out = carry_w[DIGIT];

endmodule
`default_nettype wire

// File: rtl/addsub_serial_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addsub_serial_n : digit-serial signed/unsigned add/sub, start/done         |
// |                   handshake; ADDSUB_ACCUM_EN adds acc_sel (A = res).       |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module addsub_serial_n
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             CLK_in,
   input  logic             rst,
   input  logic             start,
   input  logic             add_min,
   input  logic             symbol,
   input  logic             cin,
`ifdef ADDSUB_ACCUM_EN
   input  logic             acc_sel,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             overflow,
   output logic             busy,
   output logic             flag_end
);

   localparam int STEPS = calc_steps(WIDTH, DIGIT);
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

   if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("addsub_serial_n: WIDTH must be a multiple of DIGIT");
   end
   if (WIDTH < 2) begin : g_bad_width
      $error("addsub_serial_n: WIDTH must be at least 2");
   end

   state_t             state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [WIDTH-1:0]   opa_q,    opa_d;
   logic [WIDTH-1:0]   opb_q,    opb_d;   // already inverted for subtract
   logic               add_q,    add_d;
   logic               sym_q,    sym_d;
   logic               carry_q,  carry_d;
   logic [WIDTH-1:0]   res_q,    res_d;
   logic               cout_q,   cout_d;
   logic               ovf_q,    ovf_d;

   logic [DIGIT-1:0]   dig_a;
   logic [DIGIT-1:0]   dig_b;
   logic [DIGIT-1:0]   dig_s;
   logic               dig_c;
   logic               acc_use;
   logic               cout_new;

`ifdef ADDSUB_ACCUM_EN
   assign acc_use = acc_sel;
`else
   assign acc_use = 1'b0;
`endif

   always_comb begin
      dig_a = opa_q[int'(cnt_q) * DIGIT +: DIGIT];
      dig_b = opb_q[int'(cnt_q) * DIGIT +: DIGIT];
   end

   addsub_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a_d   (dig_a),
      .b_d   (dig_b),
      .c_in  (carry_q),
      .s_d   (dig_s),
      .c_out (dig_c)
   );

   // Subtract reports borrow, which is the inverted carry of a + ~b + ~cin.
   assign cout_new = add_q ? dig_c : ~dig_c;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      add_d   = add_q;
      sym_d   = sym_q;
      carry_d = carry_q;
      res_d   = res_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               add_d   = add_min;
               sym_d   = symbol;
               opa_d   = acc_use ? res_q : a;
               opb_d   = add_min ? b : ~b;
               carry_d = add_min ? cin : ~cin;
            end
         end
         ST_RUN: begin
            res_d[int'(cnt_q) * DIGIT +: DIGIT] = dig_s;
            carry_d = dig_c;
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
               cout_d  = cout_new;
               ovf_d   = sym_q ? ((opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                                  (dig_s[DIGIT-1] != opa_q[WIDTH-1]))
                               : cout_new;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_in) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         add_q   <= 1'b0;
         sym_q   <= 1'b0;
         carry_q <= 1'b0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         add_q   <= add_d;
         sym_q   <= sym_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign res      = res_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
   assign busy     = (state_q == ST_RUN);
   assign flag_end = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_addsub_serial_n : scoreboard bench for addsub_serial_n (8/2 and 4/4)    |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
module tb_addsub_serial_n;

   typedef struct {
      logic [7:0] r;
      logic       c;
      logic       o;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0, am8 = 1'b0, sym8 = 1'b0, cin8 = 1'b0, acc8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [7:0] res8;
   logic       cout8, ovf8, busy8, f8;

   logic       start4 = 1'b0, am4 = 1'b0, sym4 = 1'b0, cin4 = 1'b0, acc4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic [3:0] res4;
   logic       cout4, ovf4, busy4, f4;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q8[$];
   exp_t q4[$];
   exp_t e8, e4;
   logic f8_prev = 1'b0, f4_prev = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   addsub_serial_n #(.WIDTH(8), .DIGIT(2)) u_dut8 (
      .CLK_in   (clk),
      .rst      (rst),
      .start    (start8),
      .add_min  (am8),
      .symbol   (sym8),
      .cin      (cin8),
`ifdef ADDSUB_ACCUM_EN
      .acc_sel  (acc8),
`endif
      .a        (a8),
      .b        (b8),
      .res      (res8),
      .cout     (cout8),
      .overflow (ovf8),
      .busy     (busy8),
      .flag_end (f8)
   );

   addsub_serial_n #(.WIDTH(4), .DIGIT(4)) u_dut4 (
      .CLK_in   (clk),
      .rst      (rst),
      .start    (start4),
      .add_min  (am4),
      .symbol   (sym4),
      .cin      (cin4),
`ifdef ADDSUB_ACCUM_EN
      .acc_sel  (acc4),
`endif
      .a        (a4),
      .b        (b4),
      .res      (res4),
      .cout     (cout4),
      .overflow (ovf4),
      .busy     (busy4),
      .flag_end (f4)
   );

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Monitors pop one expectation per rising flag_end.
   always @(negedge clk) begin
      if (f8 && !f8_prev) begin
         if (q8.size() == 0) begin
            chk(1'b0, "dut8_unexpected_done", {22'd0, res8, cout8, ovf8}, 32'd0);
         end else begin
            e8 = q8.pop_front();
            chk({res8, cout8, ovf8} === {e8.r, e8.c, e8.o}, "dut8_result",
                {22'd0, res8, cout8, ovf8}, {22'd0, e8.r, e8.c, e8.o});
            chk(cyc == e8.cyc, "dut8_latency", cyc, e8.cyc);
         end
      end
      f8_prev = f8;
   end

   always @(negedge clk) begin
      if (f4 && !f4_prev) begin
         if (q4.size() == 0) begin
            chk(1'b0, "dut4_unexpected_done", {26'd0, res4, cout4, ovf4}, 32'd0);
         end else begin
            e4 = q4.pop_front();
            chk({4'd0, res4, cout4, ovf4} === {e4.r, e4.c, e4.o}, "dut4_result",
                {22'd0, 4'd0, res4, cout4, ovf4}, {22'd0, e4.r, e4.c, e4.o});
            chk(cyc == e4.cyc, "dut4_latency", cyc, e4.cyc);
         end
      end
      f4_prev = f4;
   end

   task automatic op8(input logic am, input logic sy, input logic ci, input logic ac,
                      input logic [7:0] av, input logic [7:0] bv, input bit push,
                      input logic [7:0] er, input logic ec, input logic eo);
      @(negedge clk);
      am8 = am; sym8 = sy; cin8 = ci; acc8 = ac; a8 = av; b8 = bv; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      if (push) q8.push_back('{er, ec, eo, cyc + 4});
      chk(!f8 && busy8, "dut8_start_accept", {30'd0, f8, busy8}, 32'd1);
      // Scramble inputs so a design that reads them live is caught.
      a8 = ~av; b8 = ~bv; am8 = ~am; sym8 = ~sy; cin8 = ~ci;
   endtask

   task automatic wait8();
      for (int i = 0; i < 20 && !f8; i++) @(negedge clk);
      if (!f8) chk(1'b0, "dut8_done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({res8, cout8, ovf8, busy8, f8} == 12'd0, "dut8_reset_state",
          {20'd0, res8, cout8, ovf8, busy8, f8}, 32'd0);
      chk({res4, cout4, ovf4, busy4, f4} == 8'd0, "dut4_reset_state",
          {24'd0, res4, cout4, ovf4, busy4, f4}, 32'd0);
      rst = 1'b0;

      //   add sy ci ac  a      b                 res    co    ov
      op8(1, 1, 0, 0, 8'h7F, 8'h01, 1, 8'h80, 1'b0, 1'b1); wait8();
      op8(0, 0, 0, 0, 8'h05, 8'h07, 1, 8'hFE, 1'b1, 1'b1); wait8();
      op8(0, 1, 1, 0, 8'h00, 8'h00, 1, 8'hFF, 1'b1, 1'b0); wait8();
      op8(1, 0, 1, 0, 8'hC8, 8'h64, 1, 8'h2D, 1'b1, 1'b1); wait8();
      op8(1, 1, 0, 0, 8'h80, 8'h80, 1, 8'h00, 1'b1, 1'b1); wait8();
      op8(1, 1, 0, 0, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b0); wait8();

      // Handshake: start during RUN is ignored, restart from DONE.
      op8(1, 0, 0, 0, 8'h12, 8'h34, 1, 8'h46, 1'b0, 1'b0);
      @(negedge clk);
      am8 = 1'b0; sym8 = 1'b1; cin8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      chk(busy8 && !f8, "dut8_run_ignores_start", {30'd0, busy8, f8}, 32'd2);
      wait8();
      op8(0, 1, 0, 0, 8'h80, 8'h01, 1, 8'h7F, 1'b0, 1'b1); wait8();
      op8(0, 1, 0, 0, 8'h7F, 8'hFF, 1, 8'h80, 1'b1, 1'b1); wait8();

      // Reset on the second RUN edge aborts the operation.
      op8(1, 0, 0, 0, 8'h01, 8'h01, 0, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk({res8, cout8, ovf8, busy8, f8} == 12'd0, "dut8_reset_midrun",
          {20'd0, res8, cout8, ovf8, busy8, f8}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      begin
         int seen = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (f8 || busy8) seen++;
         end
         chk(seen == 0, "dut8_idle_after_reset", seen, 32'd0);
      end

      // Fully parallel 4-bit instance.
      @(negedge clk);
      am4 = 1'b1; sym4 = 1'b0; cin4 = 1'b0; a4 = 4'hF; b4 = 4'h1; start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      q4.push_back('{8'h00, 1'b1, 1'b1, cyc + 1});
      chk(busy4 && !f4, "dut4_start_accept", {30'd0, busy4, f4}, 32'd2);
      for (int i = 0; i < 10 && !f4; i++) @(negedge clk);
      if (!f4) chk(1'b0, "dut4_done_timeout", 32'd0, 32'd1);

`ifdef ADDSUB_ACCUM_EN
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      op8(1, 0, 0, 1, 8'hAA, 8'h03, 1, 8'h03, 1'b0, 1'b0); wait8();
      op8(1, 0, 0, 1, 8'hAA, 8'h03, 1, 8'h06, 1'b0, 1'b0); wait8();
      op8(1, 0, 0, 1, 8'hAA, 8'h03, 1, 8'h09, 1'b0, 1'b0); wait8();
`endif

      repeat (3) @(negedge clk);
      chk(q8.size() == 0, "dut8_queue_drained", q8.size(), 32'd0);
      chk(q4.size() == 0, "dut4_queue_drained", q4.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
